// File: rtl/cp0_timer_intc.sv
// cp0_timer_intc
//   CP0 Count/Compare timer block and interrupt-pending merger.
//   Holds the free-running Count (r9 sel0) and NUM_TIMERS Compare channels
//   (r11 sel 0..NUM_TIMERS-1), synchronises the hardware interrupt pins,
//   builds Cause.IP and issues a registered, prioritised interrupt request
//   that the exception stage acknowledges with int_ack.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   reg_we                MTC0 write strobe
//   reg_write_addr/sel    write register number / select
//   reg_write             write data
//   reg_read_addr/sel     read register number / select
//   reg_read              read data (combinational)
//   reg_read_hit          read address belongs to this block
//   hardware_int          asynchronous interrupt pins
//   sw_ip                 Cause.IP[1:0] from main CP0
//   status_im/ie/exl      Status.IM, Status.IE, Status.EXL
//   count_stall           freezes Count (debug halt)
//   int_ack               exception stage took the interrupt
//   count                 current Count
//   timer_pending         sticky per-channel match flags
//   ip                    Cause.IP[7:0]
//   int_req, int_code     registered request and IP index of its cause
module cp0_timer_intc #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TIMERS  = 2,
  parameter int NUM_HW_INT  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 1,
  parameter int TIMER_IP    = 7,
  parameter int ACK_HOLDOFF = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_we,
  input  logic [4:0]            reg_write_addr,
  input  logic [2:0]            reg_write_sel,
  input  logic [DATA_WIDTH-1:0] reg_write,
  input  logic [4:0]            reg_read_addr,
  input  logic [2:0]            reg_read_sel,
  output logic [DATA_WIDTH-1:0] reg_read,
  output logic                  reg_read_hit,
  input  logic [NUM_HW_INT-1:0] hardware_int,
  input  logic [1:0]            sw_ip,
  input  logic [7:0]            status_im,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic                  count_stall,
  input  logic                  int_ack,
  output logic [DATA_WIDTH-1:0] count,
  output logic [NUM_TIMERS-1:0] timer_pending,
  output logic [7:0]            ip,
  output logic                  int_req,
  output logic [2:0]            int_code
);

  localparam int PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int HO_W  = (ACK_HOLDOFF > 0) ? $clog2(ACK_HOLDOFF + 1) : 1;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;

  logic [DATA_WIDTH-1:0] count_r;
  logic [PRE_W-1:0]      prescale_r;
  logic [DATA_WIDTH-1:0] compare_r [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] armed_r;
  logic [NUM_TIMERS-1:0] pend_r;
  logic [NUM_HW_INT-1:0] sync_r [SYNC_STAGES];
  logic                  int_req_r;
  logic [2:0]            int_code_r;
  logic [HO_W-1:0]       holdoff_r;

  logic       pre_wrap_s;
  logic       count_wr_s;
  logic       cmp_wr_s;
  logic [7:0] ip_s;
  logic [7:0] p_s;
  logic [2:0] code_s;

  assign pre_wrap_s = (prescale_r == PRE_W'(COUNT_DIV - 1));
  assign count_wr_s = reg_we && (reg_write_addr == REG_COUNT) && (reg_write_sel == 3'd0);
  assign cmp_wr_s   = reg_we && (reg_write_addr == REG_COMPARE);

  // Prescaler and Count; a software write of Count restarts the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= {DATA_WIDTH{1'b0}};
      prescale_r <= {PRE_W{1'b0}};
    end else if (count_wr_s) begin
      count_r    <= reg_write;
      prescale_r <= {PRE_W{1'b0}};
    end else begin
      prescale_r <= pre_wrap_s ? {PRE_W{1'b0}} : (prescale_r + PRE_W'(1));
      if (pre_wrap_s && !count_stall) begin
        count_r <= count_r + DATA_WIDTH'(1);
      end
    end
  end

  // Compare channels: a write re-arms and clears, otherwise a level match sets the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        compare_r[n] <= {DATA_WIDTH{1'b0}};
      end
      armed_r <= {NUM_TIMERS{1'b0}};
      pend_r  <= {NUM_TIMERS{1'b0}};
    end else begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (cmp_wr_s && (reg_write_sel == 3'(n))) begin
          compare_r[n] <= reg_write;
          armed_r[n]   <= 1'b1;
          pend_r[n]    <= 1'b0;
        end else if (armed_r[n] && (count_r == compare_r[n])) begin
          pend_r[n] <= 1'b1;
        end
      end
    end
  end

  // Synchroniser chain for the asynchronous interrupt pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {NUM_HW_INT{1'b0}};
      end
    end else begin
      sync_r[0] <= hardware_int;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Cause.IP assembly: software bits, synchronised pins, timer OR on its shared bit.
  always_comb begin
    ip_s      = 8'h00;
    ip_s[1:0] = sw_ip;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      ip_s[2+i] = sync_r[SYNC_STAGES-1][i];
    end
    ip_s[TIMER_IP] = ip_s[TIMER_IP] | (|pend_r);
  end

  assign p_s = ip_s & status_im;

  // Priority encoder: the highest set masked bit wins, 0 when nothing is pending.
  always_comb begin
    code_s = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (p_s[b]) begin
        code_s = 3'(b);
      end else begin
        code_s = code_s;
      end
    end
  end

  // Request register with acknowledge holdoff so the same cause is not re-taken immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_req_r  <= 1'b0;
      int_code_r <= 3'd0;
      holdoff_r  <= {HO_W{1'b0}};
    end else begin
      int_code_r <= code_s;
      if (int_ack && int_req_r) begin
        holdoff_r <= HO_W'(ACK_HOLDOFF);
        int_req_r <= 1'b0;
      end else begin
        if (holdoff_r != {HO_W{1'b0}}) begin
          holdoff_r <= holdoff_r - HO_W'(1);
        end
        int_req_r <= (|p_s) & status_ie & ~status_exl & (holdoff_r == {HO_W{1'b0}});
      end
    end
  end

  // Read decode: Count and the implemented Compare selects only.
  always_comb begin
    reg_read     = {DATA_WIDTH{1'b0}};
    reg_read_hit = 1'b0;
    case (reg_read_addr)
      REG_COUNT: begin
        if (reg_read_sel == 3'd0) begin
          reg_read     = count_r;
          reg_read_hit = 1'b1;
        end else begin
          reg_read     = {DATA_WIDTH{1'b0}};
          reg_read_hit = 1'b0;
        end
      end
      REG_COMPARE: begin
        for (int n = 0; n < NUM_TIMERS; n++) begin
          if (reg_read_sel == 3'(n)) begin
            reg_read     = compare_r[n];
            reg_read_hit = 1'b1;
          end else begin
            reg_read     = reg_read;
            reg_read_hit = reg_read_hit;
          end
        end
      end
      default: begin
        reg_read     = {DATA_WIDTH{1'b0}};
        reg_read_hit = 1'b0;
      end
    endcase
  end

  assign count         = count_r;
  assign timer_pending = pend_r;
  assign ip            = ip_s;
  assign int_req       = int_req_r;
  assign int_code      = int_code_r;

endmodule
